// File: rtl/interrupt_sequencer.sv
// Purpose: edge-triggered 9-source prioritised interrupt sequencer (save/mask/vector/run/restore).
// Latency: qualifying edge -> SAVE next cycle; handler fetch 3 cycles after the qualifying edge.
// Backpressure: dispatch waits for instr_boundary; handler exit waits for reti; stall holds the core.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   irq_in, irq_enable     request lines (bit 0 highest priority), global enable
//   int_mask               per-source enables from the flags register
//   instr_boundary, reti   interruptible-cycle flag, return-from-interrupt strobe
//   pc_in                  current program counter
//   r_backup, r_restore    accumulator backup/restore strobes
//   return_address_*       return address write port
//   interrupt_*            interrupt-flags write port
//   pc_load, pc_target     PC redirect
//   stall, in_isr, irq_ack processor hold, handler-running flag, one-hot acknowledge
module interrupt_sequencer #(
  parameter logic [15:0] VECTOR_BASE = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  irq_in,
  input  logic        irq_enable,
  input  logic [8:0]  int_mask,
  input  logic        instr_boundary,
  input  logic        reti,
  input  logic [15:0] pc_in,
  output logic        r_backup,
  output logic        r_restore,
  output logic [15:0] return_address_input,
  output logic        return_address_write,
  output logic [8:0]  interrupt_input,
  output logic        interrupt_write,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic        stall,
  output logic        in_isr,
  output logic [8:0]  irq_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    MASK    = 3'd2,
    VECTOR  = 3'd3,
    ACTIVE  = 3'd4,
    RESTORE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  irq_hist_q, irq_hist_d;
  logic        hist_vld_q, hist_vld_d;
  logic [8:0]  pending_q, pending_d;
  logic [3:0]  id_q, id_d;
  logic [15:0] saved_pc_q, saved_pc_d;
  logic [8:0]  saved_mask_q, saved_mask_d;

  logic [8:0]  irq_rise;
  logic [8:0]  eligible;
  logic [8:0]  pend_clr;
  logic [3:0]  winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_hist_q   <= '0;
      hist_vld_q   <= 1'b0;
      pending_q    <= '0;
      id_q         <= '0;
      saved_pc_q   <= '0;
      saved_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_hist_q   <= irq_hist_d;
      hist_vld_q   <= hist_vld_d;
      pending_q    <= pending_d;
      id_q         <= id_d;
      saved_pc_q   <= saved_pc_d;
      saved_mask_q <= saved_mask_d;
    end
  end

  // Edge detection is suppressed until the history register has sampled
  // irq_in once after reset, so lines already high at release are not edges.
  always_comb begin
    irq_hist_d = irq_in;
    hist_vld_d = 1'b1;
    irq_rise   = hist_vld_q ? (irq_in & ~irq_hist_q) : 9'h000;
    eligible   = pending_q & int_mask & {9{irq_enable}};
    // Descending scan so the lowest eligible index is the last one written.
    winner = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    saved_pc_d   = saved_pc_q;
    saved_mask_d = saved_mask_q;
    pend_clr     = 9'h000;
    case (state_q)
      IDLE: begin
        if (instr_boundary && (eligible != 9'h000)) begin
          state_d      = SAVE;
          id_d         = winner;
          saved_pc_d   = pc_in;
          saved_mask_d = int_mask;
          pend_clr     = 9'h001 << winner;
        end
      end
      SAVE:    state_d = MASK;
      MASK:    state_d = VECTOR;
      VECTOR:  state_d = ACTIVE;
      ACTIVE:  if (reti) state_d = RESTORE;
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new edge on the source being acknowledged re-arms it (set wins).
    pending_d = (pending_q & ~pend_clr) | irq_rise;
  end

  // Moore outputs: decoded purely from registered state.
  always_comb begin
    r_backup             = 1'b0;
    r_restore            = 1'b0;
    return_address_input = 16'h0000;
    return_address_write = 1'b0;
    interrupt_input      = 9'h000;
    interrupt_write      = 1'b0;
    pc_load              = 1'b0;
    pc_target            = 16'h0000;
    stall                = 1'b0;
    in_isr               = 1'b0;
    irq_ack              = 9'h000;
    case (state_q)
      SAVE: begin
        r_backup             = 1'b1;
        return_address_write = 1'b1;
        return_address_input = saved_pc_q;
        irq_ack              = 9'h001 << id_q;
        stall                = 1'b1;
      end
      MASK: begin
        interrupt_write = 1'b1;
        interrupt_input = 9'h000;
        stall           = 1'b1;
      end
      VECTOR: begin
        pc_load   = 1'b1;
        pc_target = VECTOR_BASE + {8'h00, id_q, 4'h0};
        stall     = 1'b1;
      end
      ACTIVE: begin
        in_isr = 1'b1;
      end
      RESTORE: begin
        r_restore       = 1'b1;
        interrupt_write = 1'b1;
        interrupt_input = saved_mask_q;
        pc_load         = 1'b1;
        pc_target       = saved_pc_q;
        stall           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Purpose: self-checking bench for interrupt_sequencer using a per-cycle stimulus/expectation queue.
// Latency: each queue entry is checked one cycle after the previous entry's stimulus is applied.
// Backpressure: none; the bench drives instr_boundary and reti directly.
module tb_interrupt_sequencer;

  localparam logic [15:0] VB = 16'h0100;

  typedef struct packed {
    logic        r_backup;
    logic        r_restore;
    logic [15:0] ra_in;
    logic        ra_wr;
    logic [8:0]  int_in;
    logic        int_wr;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        stall;
    logic        in_isr;
    logic [8:0]  irq_ack;
  } outs_t;

  typedef struct packed {
    logic [8:0]  irq;
    logic [8:0]  mask;
    logic        en;
    logic        bnd;
    logic        reti;
    logic [15:0] pc;
  } stim_t;

  logic        clk;
  logic        rst_n;
  logic [8:0]  irq_in;
  logic        irq_enable;
  logic [8:0]  int_mask;
  logic        instr_boundary;
  logic        reti;
  logic [15:0] pc_in;
  logic        r_backup;
  logic        r_restore;
  logic [15:0] return_address_input;
  logic        return_address_write;
  logic [8:0]  interrupt_input;
  logic        interrupt_write;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        stall;
  logic        in_isr;
  logic [8:0]  irq_ack;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: expected outputs at a negedge, paired with inputs driven right after.
  outs_t exp_q[$];
  stim_t stim_q[$];
  string name_q[$];

  logic [8:0]  cur_irq  = 9'h000;
  logic [8:0]  cur_mask = 9'h1FF;
  logic        cur_en   = 1'b1;
  logic        cur_bnd  = 1'b1;
  logic        cur_reti = 1'b0;
  logic [15:0] cur_pc   = 16'h0000;

  interrupt_sequencer #(.VECTOR_BASE(VB)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .irq_in               (irq_in),
    .irq_enable           (irq_enable),
    .int_mask             (int_mask),
    .instr_boundary       (instr_boundary),
    .reti                 (reti),
    .pc_in                (pc_in),
    .r_backup             (r_backup),
    .r_restore            (r_restore),
    .return_address_input (return_address_input),
    .return_address_write (return_address_write),
    .interrupt_input      (interrupt_input),
    .interrupt_write      (interrupt_write),
    .pc_load              (pc_load),
    .pc_target            (pc_target),
    .stall                (stall),
    .in_isr               (in_isr),
    .irq_ack              (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outs_t outs_now();
    outs_t o;
    o.r_backup  = r_backup;
    o.r_restore = r_restore;
    o.ra_in     = return_address_input;
    o.ra_wr     = return_address_write;
    o.int_in    = interrupt_input;
    o.int_wr    = interrupt_write;
    o.pc_load   = pc_load;
    o.pc_target = pc_target;
    o.stall     = stall;
    o.in_isr    = in_isr;
    o.irq_ack   = irq_ack;
    return o;
  endfunction

  function automatic outs_t exp_idle();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t exp_save(input logic [15:0] pc, input int id);
    outs_t o = '0;
    o.r_backup   = 1'b1;
    o.ra_wr      = 1'b1;
    o.ra_in      = pc;
    o.irq_ack[id] = 1'b1;
    o.stall      = 1'b1;
    return o;
  endfunction

  function automatic outs_t exp_mask();
    outs_t o = '0;
    o.int_wr = 1'b1;
    o.stall  = 1'b1;
    return o;
  endfunction

  function automatic outs_t exp_vector(input int id);
    outs_t o = '0;
    o.pc_load   = 1'b1;
    o.pc_target = VB + 16'(id * 16);
    o.stall     = 1'b1;
    return o;
  endfunction

  function automatic outs_t exp_active();
    outs_t o = '0;
    o.in_isr = 1'b1;
    return o;
  endfunction

  function automatic outs_t exp_restore(input logic [8:0] m, input logic [15:0] pc);
    outs_t o = '0;
    o.r_restore = 1'b1;
    o.int_wr    = 1'b1;
    o.int_in    = m;
    o.pc_load   = 1'b1;
    o.pc_target = pc;
    o.stall     = 1'b1;
    return o;
  endfunction

  // Queue one cycle: expectation at the next negedge, then the current input snapshot.
  task automatic add(input string nm, input outs_t e);
    stim_t s;
    s.irq  = cur_irq;
    s.mask = cur_mask;
    s.en   = cur_en;
    s.bnd  = cur_bnd;
    s.reti = cur_reti;
    s.pc   = cur_pc;
    exp_q.push_back(e);
    stim_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    outs_t e, act;
    stim_t s;
    string nm;
    rst_n = 1'b0;
    irq_in = 9'h001; irq_enable = 1'b1; int_mask = 9'h1FF;
    instr_boundary = 1'b1; reti = 1'b0; pc_in = 16'h0000;
    cur_irq = 9'h001;
    #3;
    act = outs_now();
    n_assert++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", act);
    end
    n_assert++;
    if (dut.pending_q !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_pending: got %h want 000", dut.pending_q);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // irq_in[0] held high across release must not count as an edge.
    add("hist_idle0", exp_idle());
    add("hist_idle1", exp_idle());
    add("hist_idle2", exp_idle());
    cur_irq = 9'h000;
    add("hist_idle3", exp_idle());
    add("hist_idle4", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
  endtask

  task automatic test_single();
    outs_t e, act;
    stim_t s;
    string nm;
    cur_irq = 9'h004; cur_pc = 16'h0234; cur_mask = 9'h1FF;
    add("single_idle0", exp_idle());
    cur_irq = 9'h000;
    add("single_idle1", exp_idle());
    add("single_save", exp_save(16'h0234, 2));
    add("single_mask", exp_mask());
    add("single_vector", exp_vector(2));
    cur_reti = 1'b1;
    add("single_active", exp_active());
    cur_reti = 1'b0;
    add("single_restore", exp_restore(9'h1FF, 16'h0234));
    add("single_idle_end", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
  endtask

  task automatic test_priority();
    outs_t e, act;
    stim_t s;
    string nm;
    cur_irq = 9'h022; cur_pc = 16'h0300;
    add("prio_idle0", exp_idle());
    cur_irq = 9'h000;
    add("prio_idle1", exp_idle());
    add("prio_save1", exp_save(16'h0300, 1));
    add("prio_mask1", exp_mask());
    cur_pc = 16'h0400;
    add("prio_vector1", exp_vector(1));
    cur_reti = 1'b1;
    add("prio_active1", exp_active());
    cur_reti = 1'b0;
    add("prio_restore1", exp_restore(9'h1FF, 16'h0300));
    add("prio_idle2", exp_idle());
    add("prio_save5", exp_save(16'h0400, 5));
    add("prio_mask5", exp_mask());
    add("prio_vector5", exp_vector(5));
    cur_reti = 1'b1;
    add("prio_active5", exp_active());
    cur_reti = 1'b0;
    add("prio_restore5", exp_restore(9'h1FF, 16'h0400));
    add("prio_idle3", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
  endtask

  task automatic test_masked_pending();
    outs_t e, act;
    stim_t s;
    string nm;
    cur_mask = 9'h1F7; cur_irq = 9'h008; cur_pc = 16'h0500;
    add("mask_idle0", exp_idle());
    cur_irq = 9'h000;
    add("mask_idle1", exp_idle());
    add("mask_held", exp_idle());
    cur_mask = 9'h1FF;
    add("mask_held2", exp_idle());
    add("mask_save3", exp_save(16'h0500, 3));
    add("mask_mask3", exp_mask());
    add("mask_vector3", exp_vector(3));
    cur_irq = 9'h080;
    add("mask_active3a", exp_active());
    cur_irq = 9'h000; cur_reti = 1'b1;
    add("mask_active3b", exp_active());
    cur_reti = 1'b0;
    add("mask_restore3", exp_restore(9'h1FF, 16'h0500));
    add("mask_idle2", exp_idle());
    add("mask_save7", exp_save(16'h0500, 7));
    add("mask_mask7", exp_mask());
    add("mask_vector7", exp_vector(7));
    cur_reti = 1'b1;
    add("mask_active7", exp_active());
    cur_reti = 1'b0;
    add("mask_restore7", exp_restore(9'h1FF, 16'h0500));
    add("mask_idle3", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
  endtask

  task automatic test_saved_mask();
    outs_t e, act;
    stim_t s;
    string nm;
    cur_mask = 9'h0F0; cur_irq = 9'h010; cur_pc = 16'h1000;
    add("smask_idle0", exp_idle());
    cur_irq = 9'h000;
    add("smask_idle1", exp_idle());
    add("smask_save", exp_save(16'h1000, 4));
    add("smask_mask", exp_mask());
    add("smask_vector", exp_vector(4));
    cur_reti = 1'b1;
    add("smask_active", exp_active());
    cur_reti = 1'b0;
    add("smask_restore", exp_restore(9'h0F0, 16'h1000));
    cur_reti = 1'b1;
    add("smask_idle", exp_idle());
    cur_reti = 1'b0;
    add("stray_reti_idle0", exp_idle());
    add("stray_reti_idle1", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
    cur_mask = 9'h1FF;
  endtask

  task automatic test_back_to_back();
    outs_t e, act;
    stim_t s;
    string nm;
    // Held off by instr_boundary, then a re-edge on the same source as it is acknowledged.
    cur_bnd = 1'b0; cur_irq = 9'h040; cur_pc = 16'h0600;
    add("b2b_idle0", exp_idle());
    cur_irq = 9'h000;
    add("b2b_noboundary0", exp_idle());
    cur_irq = 9'h040; cur_bnd = 1'b1;
    add("b2b_noboundary1", exp_idle());
    cur_irq = 9'h000;
    add("b2b_save_a", exp_save(16'h0600, 6));
    add("b2b_mask_a", exp_mask());
    add("b2b_vector_a", exp_vector(6));
    cur_reti = 1'b1;
    add("b2b_active_a", exp_active());
    cur_reti = 1'b0;
    add("b2b_restore_a", exp_restore(9'h1FF, 16'h0600));
    add("b2b_idle_a", exp_idle());
    add("b2b_save_b", exp_save(16'h0600, 6));
    add("b2b_mask_b", exp_mask());
    add("b2b_vector_b", exp_vector(6));
    cur_reti = 1'b1;
    add("b2b_active_b", exp_active());
    cur_reti = 1'b0;
    add("b2b_restore_b", exp_restore(9'h1FF, 16'h0600));
    add("b2b_idle_b", exp_idle());
    add("b2b_idle_c", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
  endtask

  task automatic test_reset_mid();
    outs_t e, act;
    stim_t s;
    string nm;
    cur_irq = 9'h001; cur_pc = 16'h55AA; cur_mask = 9'h0FF;
    add("rmid_idle0", exp_idle());
    cur_irq = 9'h000;
    add("rmid_idle1", exp_idle());
    cur_irq = 9'h100;
    add("rmid_save", exp_save(16'h55AA, 0));
    cur_irq = 9'h000;
    add("rmid_mask", exp_mask());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
    n_assert++;
    if (dut.pending_q !== 9'h100) begin
      n_fail++;
      $display("FAIL rmid_pending_before: got %h want 100", dut.pending_q);
    end
    #2 rst_n = 1'b0;
    #1;
    act = outs_now();
    n_assert++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL rmid_async_outs: got %h want 0", act);
    end
    n_assert++;
    if (dut.pending_q !== 9'h000) begin
      n_fail++;
      $display("FAIL rmid_async_pending: got %h want 000", dut.pending_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_mask = 9'h1FF; cur_reti = 1'b1;
    add("rmid_post0", exp_idle());
    cur_reti = 1'b0;
    add("rmid_post1", exp_idle());
    add("rmid_post2", exp_idle());
    add("rmid_post3", exp_idle());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); s = stim_q.pop_front(); nm = name_q.pop_front();
      act = outs_now();
      n_assert++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
      irq_in = s.irq; int_mask = s.mask; irq_enable = s.en;
      instr_boundary = s.bnd; reti = s.reti; pc_in = s.pc;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked_pending();
    test_saved_mask();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter VECTOR_BASE, default 16'h0100, base address of the interrupt vector table.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 irq_in  in  9  interrupt request lines; bit 0 is highest priority.
REQ-005 irq_enable  in  1  global interrupt enable.
REQ-006 int_mask  in  9  current interrupt enable bits from the flags register (flag_output[11:3]).
REQ-007 instr_boundary  in  1  high when the processor may be interrupted this cycle.
REQ-008 reti  in  1  return-from-interrupt strobe, one cycle.
REQ-009 pc_in  in  16  current program counter.
REQ-010 r_backup  out  1  drives register file accumulator backup.
REQ-011 r_restore  out  1  drives register file accumulator restore.
REQ-012 return_address_input / return_address_write  out  16 / 1  return address write port.
REQ-013 interrupt_input / interrupt_write  out  9 / 1  interrupt-flags write port.
REQ-014 pc_load / pc_target  out  1 / 16  PC redirect strobe and address.
REQ-015 stall  out  1  processor hold.
REQ-016 in_isr  out  1  high while a handler is running.
REQ-017 irq_ack  out  9  one-hot, one-cycle acknowledge of the dispatched source.

Function
REQ-018 pending[i] SHALL set on a 0->1 transition of irq_in[i], sampled against a registered copy of irq_in.
REQ-019 The sequencer SHALL compute eligible = pending & int_mask & {9{irq_enable}}.
REQ-020 The sequencer SHALL select the lowest-index eligible bit as the winner id (0..8).
REQ-021 The FSM SHALL have the states IDLE, SAVE, MASK, VECTOR, ACTIVE and RESTORE.
REQ-022 All outputs SHALL decode from the registered state (Moore).
REQ-023 IDLE -> SAVE: on a clock edge with instr_boundary=1 and eligible!=0; on that same edge the sequencer latches id, saved_pc=pc_in and saved_mask=int_mask, and clears pending[id].
REQ-024 SAVE (1 cycle): r_backup=1, return_address_write=1, return_address_input=saved_pc, irq_ack[id]=1, stall=1.
REQ-025 MASK (1 cycle): interrupt_write=1, interrupt_input=9'h000, stall=1.
REQ-026 VECTOR (1 cycle): pc_load=1, pc_target=VECTOR_BASE + (id<<4), stall=1.
REQ-027 ACTIVE: in_isr=1, stall=0; the FSM SHALL leave ACTIVE for RESTORE only on reti=1.
REQ-028 RESTORE (1 cycle): r_restore=1, interrupt_write=1, interrupt_input=saved_mask, pc_load=1, pc_target=saved_pc, stall=1; then the FSM SHALL return to IDLE.
REQ-029 Latency: qualifying edge -> SAVE next cycle; first handler fetch 3 cycles after the qualifying edge.
REQ-030 Handlers SHALL NOT nest; irq edges during SAVE..RESTORE SHALL still latch into pending.
REQ-031 An edge on irq_in[id] in the same cycle pending[id] is cleared SHALL leave pending[id]=1 (set wins).
REQ-032 reti outside ACTIVE SHALL be ignored.
REQ-033 A pending bit whose mask or enable is off SHALL be retained until it becomes eligible.
REQ-034 In IDLE every strobe SHALL be 0 and the data outputs SHALL be 0.

Reset
REQ-035 rst_n=0 SHALL immediately force: state=IDLE, pending=0, irq_in history=0, id/saved_pc/saved_mask=0, and all outputs 0, including during mid-sequence.
REQ-036 After rst_n deasserts, the first edge SHALL be detected only after one cycle of history sampling.

Verification
REQ-037 Scenario: int_mask=9'h1FF, irq_enable=1, pc_in=16'h0234, pulse irq_in[2], instr_boundary=1 -> SAVE (ret addr 0x0234, ack=9'h004), then MASK (flags 0), then VECTOR (pc_target 0x0120), then ACTIVE.
REQ-038 Scenario: irq_in[5] and irq_in[1] rise together -> bit 1 dispatched (pc_target 0x0110); after reti and RESTORE, bit 5 is dispatched next (pc_target 0x0150).
REQ-039 Scenario: irq_in[3] rises with int_mask[3]=0 -> no dispatch; once int_mask[3]=1 -> dispatch to 0x0130.
REQ-040 Scenario: in ACTIVE, saved_mask=9'h0F0, pulse reti -> RESTORE with r_restore=1, interrupt_input=9'h0F0, pc_target=saved_pc; then IDLE with in_isr=0.
REQ-041 Scenario: instr_boundary=0 with eligible!=0 -> FSM stays IDLE with stall=0; dispatch occurs on the first cycle with instr_boundary=1.
REQ-042 Scenario: rst_n asserted during MASK -> all outputs 0 and pending=0 asynchronously; a reti after release has no effect.
